// File: rtl/qar_fetch.sv
// QAR-Core instruction fetch: sequential fetch under a credit rule, in-order prefetch FIFO, redirect flush.
// Optional macro QAR_FETCH_PERF_EN adds the fetch_stall_cnt decode-starvation counter.
module qar_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
`ifdef QAR_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_stall_cnt
`endif
);

    localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_addr, fetch_addr_n;
    logic [31:0]   rsp_pc, rsp_pc_n;
    logic [CW-1:0] outstanding, outstanding_n;
    logic [CW-1:0] drop_cnt, drop_cnt_n;
    logic [CW-1:0] fifo_count, count_n;
    logic [PW-1:0] rd_ptr, rd_n, wr_ptr, wr_n;
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];

    logic credit, accept, drop, push, pop;

    // Credit reserves a FIFO slot for every outstanding request, so responses never stall.
    assign credit = (outstanding < CW'(MAX_OUTSTANDING)) &&
                    (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));

    assign imem_req_valid = ~rst & ~redirect_valid & credit;
    assign imem_req_addr  = fetch_addr;
    assign accept         = imem_req_valid & imem_req_ready;
    assign drop           = (drop_cnt != '0);
    assign push           = imem_rsp_valid & ~redirect_valid & ~drop;
    assign instr_valid    = (fifo_count != '0);
    assign pop            = instr_valid & instr_ready & ~redirect_valid;
    assign instr_data     = instr_valid ? fifo_data[rd_ptr] : NOP;
    assign instr_pc       = instr_valid ? fifo_pc[rd_ptr] : 32'h0;

    // Next-state; a redirect overrides every other update this cycle.
    always_comb begin
        fetch_addr_n  = fetch_addr;
        rsp_pc_n      = rsp_pc;
        outstanding_n = outstanding + CW'(accept) - CW'(imem_rsp_valid);
        drop_cnt_n    = drop_cnt;
        count_n       = fifo_count;
        rd_n          = rd_ptr;
        wr_n          = wr_ptr;
        if (redirect_valid) begin
            fetch_addr_n = redirect_pc & ~32'h3;
            rsp_pc_n     = redirect_pc & ~32'h3;
            drop_cnt_n   = outstanding - CW'(imem_rsp_valid);
            count_n      = '0;
            rd_n         = '0;
            wr_n         = '0;
        end else begin
            if (accept) begin
                fetch_addr_n = fetch_addr + 32'd4;
            end
            if (imem_rsp_valid && drop) begin
                drop_cnt_n = drop_cnt - CW'(1);
            end
            // Surviving responses are contiguous from the last restart point.
            if (push) begin
                wr_n     = wr_ptr + PW'(1);
                rsp_pc_n = rsp_pc + 32'd4;
            end
            if (pop) begin
                rd_n = rd_ptr + PW'(1);
            end
            count_n = fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_addr  <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            fetch_addr  <= fetch_addr_n;
            rsp_pc      <= rsp_pc_n;
            outstanding <= outstanding_n;
            drop_cnt    <= drop_cnt_n;
            fifo_count  <= count_n;
            rd_ptr      <= rd_n;
            wr_ptr      <= wr_n;
        end
    end

    // FIFO storage needs no reset; the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= rsp_pc;
        end
    end

`ifdef QAR_FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_stall_cnt <= '0;
        end else if (instr_ready && !instr_valid) begin
            fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_qar_fetch.sv
// Randomized scoreboard bench for qar_fetch: memory model plus an instruction-stream reference.
module tb_qar_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_data, instr_pc;
`ifdef QAR_FETCH_PERF_EN
    logic [31:0] fetch_stall_cnt;
    int unsigned exp_stall;
`endif

    qar_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc)
`ifdef QAR_FETCH_PERF_EN
        , .fetch_stall_cnt(fetch_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; int due; } mem_e_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ins_t;

    mem_e_t      mem_q[$];   // accepted requests awaiting a memory response
    ins_t        exp_q[$];   // instructions that should sit in the prefetch FIFO
    logic [31:0] exp_fetch;
    int          cyc = 0, last_due = 0;
    int          lat_min = 1, lat_max = 1, rdy_pct = 100;
    int          checks = 0, failures = 0, pops = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h0010_0093 + a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 40) $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Memory: random acceptance, in-order responses after a per-request latency.
    always @(posedge clk) begin
        #1;
        cyc++;
        imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    end

    // Request side: record what the upcoming edge accepts, delivers and redirects.
    always @(negedge clk) begin
        mem_e_t e;
        int d;
        #1;
        if (rst) begin
            mem_q.delete();
            exp_q.delete();
            exp_fetch = RESET_PC;
            last_due  = 0;
        end else begin
            if (redirect_valid) begin
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                exp_q.delete();
            end
            if (imem_rsp_valid && mem_q.size() > 0) begin
                e = mem_q.pop_front();
                if (!e.stale) exp_q.push_back('{pc: e.addr, data: word(e.addr)});
            end
            if (imem_req_valid && imem_req_ready) begin
                d = cyc + int'($urandom_range(lat_max, lat_min));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mem_q.push_back('{addr: imem_req_addr, stale: redirect_valid, due: d});
                if (!redirect_valid) exp_fetch = exp_fetch + 32'd4;
            end
            if (redirect_valid) exp_fetch = redirect_pc & ~32'h3;
        end
    end

    // Monitor: compare DUT outputs with the reference and retire consumed instructions.
    always @(negedge clk) begin
        bit exp_rv, exp_iv;
        if (rst) begin
            chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
            chk("rst_req_addr", imem_req_addr, RESET_PC);
            chk("rst_instr_valid", 32'(instr_valid), 32'd0);
            chk("rst_instr_data", instr_data, NOP);
            chk("rst_instr_pc", instr_pc, 32'h0);
`ifdef QAR_FETCH_PERF_EN
            chk("rst_stall_cnt", fetch_stall_cnt, 32'd0);
            exp_stall = 0;
`endif
        end else begin
            exp_rv = !redirect_valid && mem_q.size() < MAXO && (mem_q.size() + exp_q.size()) < DEPTH;
            exp_iv = (exp_q.size() != 0);
            chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            if (imem_req_valid && exp_rv) chk("req_addr", imem_req_addr, exp_fetch);
            chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
            if (exp_iv) begin
                chk("instr_pc", instr_pc, exp_q[0].pc);
                chk("instr_data", instr_data, exp_q[0].data);
                if (instr_ready && !redirect_valid) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end else begin
                chk("idle_data", instr_data, NOP);
                chk("idle_pc", instr_pc, 32'h0);
            end
`ifdef QAR_FETCH_PERF_EN
            chk("stall_cnt", fetch_stall_cnt, exp_stall);
            if (instr_ready && !exp_iv) exp_stall++;
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic redir(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step(1);
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        step(3);
        rst = 1'b0;
        step(30);                       // zero-wait streaming
        instr_ready = 1'b0; step(20);   // decode backpressure fills the FIFO
        instr_ready = 1'b1; step(10);
        lat_min = 3; lat_max = 3; step(10);
        redir(32'h0000_0100); step(15);
        redir(32'hFFFF_FFF8); step(12);
        redir(32'h0000_0103); step(10);
        redir(32'h0000_0200); redir(32'h0000_0300); step(10);
        lat_min = 1; lat_max = 1;
        instr_ready = 1'b0; step(4);
        rst = 1'b1; step(2); rst = 1'b0;
        instr_ready = 1'b1; step(12);
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                lat_min = int'($urandom_range(2, 1));
                lat_max = lat_min + int'($urandom_range(3, 0));
                rdy_pct = int'($urandom_range(100, 30));
            end
            instr_ready = ($urandom_range(99) < 75);
            if ($urandom_range(999) < 3) begin
                rst = 1'b1; step(2); rst = 1'b0;
            end else if ($urandom_range(99) < 3) begin
                redir($urandom);
            end else begin
                step(1);
            end
        end
        lat_min = 1; lat_max = 1; rdy_pct = 100; instr_ready = 1'b1;
        step(20);
        chk("progress", 32'(pops > 500), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qar_fetch.md
Name: qar_fetch

Overview:
Instruction fetch stage for QAR-Core, directly upstream of the decode/execute core.
- Generates sequential word-aligned fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Collects in-order responses into a small prefetch FIFO and presents {instruction, PC} to decode over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes the FIFO and discards in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
FIFO_DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests; range 1..FIFO_DEPTH.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_req_addr  output  32  fetch byte address; bits [1:0] always 0.
imem_rsp_valid  input  1  response valid; in order, at most one per cycle, at least 1 cycle after acceptance.
imem_rsp_data  input  32  instruction word.
redirect_valid  input  1  flush the stage and restart fetch at redirect_pc.
redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
instr_valid  output  1  FIFO head holds a valid instruction.
instr_ready  input  1  decode consumes the head this cycle.
instr_data  output  32  head instruction; 32'h0000_0013 (NOP) when instr_valid=0.
instr_pc  output  32  head PC; 0 when instr_valid=0.

Behaviour:
- Reset (async assert): imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr_data=32'h00000013, instr_pc=0. FIFO, outstanding count and drop count are cleared.
- First cycle after rst deasserts: imem_req_valid=1 with imem_req_addr=RESET_PC.
- Issue condition: imem_req_valid=1 iff outstanding < MAX_OUTSTANDING, (outstanding + fifo_count) < FIFO_DEPTH, and redirect_valid=0. This credit rule guarantees every response has a FIFO slot, so the response channel has no backpressure.
- On acceptance (imem_req_valid & imem_req_ready): outstanding increments, the entry records its PC, and imem_req_addr advances by 4 for the next cycle.
- Address wraps modulo 2^32; 32'hFFFF_FFFC is followed by 0.
- While a request is unaccepted, imem_req_addr is held stable. The request may be withdrawn only by redirect; memory treats an unaccepted request as never issued.
- Response, no drop pending: the word and its PC are written to the FIFO tail at the end of that cycle, and outstanding decrements.
- Response, drop_cnt > 0: the response is discarded, and drop_cnt and outstanding both decrement.
- Same-cycle acceptance and response: outstanding is unchanged.
- Output path: instr_valid = (fifo_count != 0); instr_data/instr_pc come from the FIFO head. A pop occurs when instr_valid & instr_ready.
- Simultaneous push and pop: fifo_count is unchanged; both are allowed when full or empty, within credit.
- Latency with a zero-wait memory: accept in cycle N, response in N+1, instr_valid=1 in N+2. There is no FIFO bypass.
- Sustained throughput is 1 instruction/cycle when MAX_OUTSTANDING >= 2 and memory latency is 1.
- Redirect (highest priority), in the redirect cycle:
  - no request is issued;
  - any pop is ignored;
  - any response is discarded.
- Redirect, at the next edge:
  - FIFO is emptied, so instr_valid=0 the next cycle;
  - fetch address becomes {redirect_pc[31:2],2'b00};
  - drop_cnt is set to outstanding minus (imem_rsp_valid ? 1 : 0).
- Back-to-back redirects: the last one wins; drop_cnt is recomputed each time from the current outstanding count.
- Requests resume the cycle after redirect if the credit rule allows; drop-pending requests still count as outstanding for credit.
- rst asserted mid-operation: all state clears immediately. Responses to pre-reset requests must not be delivered by memory, since the memory shares the same reset.

Optional Feature:
QAR_FETCH_PERF_EN
- Defined: adds output port fetch_stall_cnt (32 bits), reset to 0. It increments, wrapping, on every cycle where instr_ready=1 and instr_valid=0, counting decode starvation.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Zero-wait memory returning word 32'h00100093+addr, instr_ready=1 always -> requests at 0x0,0x4,0x8,... on consecutive cycles; first instr_valid 2 cycles after first accept; then one instr per cycle with instr_pc 0x0,0x4,0x8.
- instr_ready=0 for 20 cycles, FIFO_DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0; FIFO holds PCs 0x0..0xC. Releasing instr_ready drains all four in order with no loss or duplication.
- Memory with latency 3 and 2 requests outstanding, then redirect_valid with redirect_pc=0x100 -> both stale responses discarded; next delivered instr_pc=0x100 then 0x104; no instruction from 0x8/0xC appears.
- Redirect in the same cycle as a response and an instr_ready pop -> that response is dropped; the head is not double-consumed; instr_valid=0 the next cycle; drop_cnt equals outstanding-1.
- redirect_pc=0xFFFF_FFF8 -> fetched PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x0; redirect_pc=0x103 -> first PC 0x100.
- rst pulsed mid-stream with 3 FIFO entries -> immediately instr_valid=0, instr_data=0x00000013, imem_req_valid=0. After release, first request is at RESET_PC. With QAR_FETCH_PERF_EN, fetch_stall_cnt=0 after reset and counts the 2 starved cycles before the first delivery.
